fpu_tile_arbiter: RTL and testbench
===================================

FPU_TILE_ARBITER -- requirements
Module: fpu_tile_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter CSR_WIDTH, default 16, control/status word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum wait for a tile result.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  2  per-requester operation request.
REQ-007 req_ready  output  2  per-requester accept; transfer when valid&ready.
REQ-008 req_op_a, req_op_b  input  2xREG_WIDTH  per-requester operands.
REQ-009 req_sub  input  2  per-requester op: 0 add, 1 subtract.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumer accept.
REQ-012 rsp_id  output  1  requester index owning the response.
REQ-013 rsp_result  output  REG_WIDTH  tile result.
REQ-014 rsp_status  output  CSR_WIDTH  tile csr_out captured with the result.
REQ-015 rsp_timeout  output  1  response ended by timeout, result invalid.
REQ-016 data_reg_a, data_reg_b  output  REG_WIDTH  tile operands.
REQ-017 csr_in  output  CSR_WIDTH  tile control; bit15 start, bit4 subtract, others 0.
REQ-018 csr_in_re  output  1  one-cycle strobe: csr_in/data_reg_a/b valid for the tile.
REQ-019 csr_out  input  CSR_WIDTH  tile status.
REQ-020 csr_out_we  input  1  tile result strobe; data_reg_c and csr_out valid this cycle.
REQ-021 data_reg_c  input  REG_WIDTH  tile result.

Function
REQ-022 FSM states IDLE, ISSUE, WAIT, RESP; exactly one tile operation in flight.
REQ-023 IDLE: req_ready asserted only to the granted requester, only in IDLE; on handshake latch op_a, op_b, sub, id, go to ISSUE.
REQ-024 Arbitration round-robin: if both valid, grant the requester not granted last; single valid requester always granted; last-grant pointer reset to 1 (requester 0 wins first tie).
REQ-025 Grant computed combinationally from req_valid and pointer; pointer updates only on handshake.
REQ-026 ISSUE (1 cycle): drive latched operands, csr_in = 0x8000 add / 0x8010 sub, csr_in_re=1; clear timeout counter; go to WAIT.
REQ-027 Outside ISSUE csr_in_re=0 and csr_in=0; data_reg_a/b hold last issued values.
REQ-028 WAIT: on csr_out_we capture data_reg_c, csr_out into rsp regs, rsp_timeout=0, go to RESP.
REQ-029 WAIT: counter increments per cycle; at TIMEOUT_CYCLES-1 without csr_out_we, go to RESP with rsp_result=0, rsp_status=0, rsp_timeout=1.
REQ-030 csr_out_we in the timeout cycle wins: result captured, rsp_timeout=0.
REQ-031 csr_out_we outside WAIT is ignored.
REQ-032 RESP: rsp_valid=1, rsp_* stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
REQ-033 Minimum request-to-response latency: handshake cycle N, csr_in_re at N+1, csr_out_we earliest N+2, rsp_valid at N+3.
REQ-034 Back-to-back: next req_ready earliest cycle after response handshake.
REQ-035 Counter width clog2(TIMEOUT_CYCLES)+1; no wrap possible.

Reset
REQ-036 On arst_n low: state IDLE, req_ready=0 until first edge after release, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_status=0, rsp_timeout=0, csr_in=0, csr_in_re=0, data_reg_a/b=0, counter=0, pointer=1.
REQ-037 Reset mid-operation abandons the operation; a late csr_out_we after release is ignored (IDLE).

Structure
REQ-038 Shared package fpu_tile_pkg: FSM state enum, CSR_START_BIT=15, CSR_SUB_BIT=4, CSR_ADD_CMD=0x8000, CSR_SUB_CMD=0x8010.
REQ-039 One sub-module rr_arbiter_2 (2-way round-robin grant, pointer inside); rest flat.

Verification
REQ-040 Req0 a=0x41200000 b=0x40A00000 sub=0, tile returns 0x41700000 -> csr_in=0x8000 strobe, rsp_id=0, rsp_result=0x41700000, rsp_timeout=0.
REQ-041 Req1 a=0x41600000 b=0x40A00000 sub=1 -> csr_in=0x8010, rsp_id=1, rsp_result=0x41100000.
REQ-042 Both req_valid held for 4 ops -> grant order 0,1,0,1; exactly one csr_in_re per response.
REQ-043 Tile silent, TIMEOUT_CYCLES=8 -> rsp_valid 8 cycles after csr_in_re, rsp_timeout=1, rsp_result=0.
REQ-044 rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0 throughout, no new csr_in_re.
REQ-045 arst_n pulsed low during WAIT, then csr_out_we -> all outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/fpu_tile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_tile_pkg : FSM encoding and tile CSR command words shared by the arbiter
// Revision     : 1.0
// ---------------------------------------------------------------------------
package fpu_tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int          CSR_START_BIT = 15;
  localparam int          CSR_SUB_BIT   = 4;
  localparam logic [15:0] CSR_ADD_CMD   = 16'(1 << CSR_START_BIT);
  localparam logic [15:0] CSR_SUB_CMD   = CSR_ADD_CMD | 16'(1 << CSR_SUB_BIT);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter_2 : two-way round-robin grant; pointer remembers the last winner
// Revision     : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_tile_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_tile_arbiter : shares one FPU tile between two requesters, one op in flight
// Revision         : 1.0
// ---------------------------------------------------------------------------
module fpu_tile_arbiter
  import fpu_tile_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int CSR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][REG_WIDTH-1:0] req_op_a,
  input  logic [1:0][REG_WIDTH-1:0] req_op_b,
  input  logic [1:0]                req_sub,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [REG_WIDTH-1:0]      rsp_result,
  output logic [CSR_WIDTH-1:0]      rsp_status,
  output logic                      rsp_timeout,
  output logic [REG_WIDTH-1:0]      data_reg_a,
  output logic [REG_WIDTH-1:0]      data_reg_b,
  output logic [CSR_WIDTH-1:0]      csr_in,
  output logic                      csr_in_re,
  input  logic [CSR_WIDTH-1:0]      csr_out,
  input  logic                      csr_out_we,
  input  logic [REG_WIDTH-1:0]      data_reg_c
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             started;
  logic             cur_id;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       grant;
  logic             handshake;
  logic             gid;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .arst_n  (arst_n),
    .valid   (req_valid),
    .advance (handshake),
    .grant   (grant)
  );

  // started keeps req_ready low until the first edge after reset release.
  assign req_ready = (started && state == ST_IDLE) ? grant : 2'b00;
  assign handshake = |(req_valid & req_ready);
  assign gid       = grant[1];
  assign cnt_nxt   = cnt + 1'b1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_IDLE;
      started     <= 1'b0;
      cur_id      <= 1'b0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_status  <= '0;
      rsp_timeout <= 1'b0;
      data_reg_a  <= '0;
      data_reg_b  <= '0;
      csr_in      <= '0;
      csr_in_re   <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ST_IDLE: begin
          // Operands go straight into the tile-facing registers, which then hold them.
          if (handshake) begin
            cur_id     <= gid;
            data_reg_a <= req_op_a[gid];
            data_reg_b <= req_op_b[gid];
            csr_in     <= CSR_WIDTH'(req_sub[gid] ? CSR_SUB_CMD : CSR_ADD_CMD);
            csr_in_re  <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          csr_in    <= '0;
          csr_in_re <= 1'b0;
          cnt       <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt_nxt;
          // A tile result arriving in the timeout cycle still takes priority.
          if (csr_out_we) begin
            rsp_result  <= data_reg_c;
            rsp_status  <= csr_out;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (cnt_nxt == CNT_LAST) begin
            rsp_result  <= '0;
            rsp_status  <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_tile_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fpu_tile_arbiter : scoreboard bench with a behavioural tile model
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_fpu_tile_arbiter;

  localparam int RW = 32;
  localparam int CW = 16;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                arst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][RW-1:0]  req_op_a;
  logic [1:0][RW-1:0]  req_op_b;
  logic [1:0]          req_sub;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [RW-1:0]       rsp_result;
  logic [CW-1:0]       rsp_status;
  logic                rsp_timeout;
  logic [RW-1:0]       data_reg_a;
  logic [RW-1:0]       data_reg_b;
  logic [CW-1:0]       csr_in;
  logic                csr_in_re;
  logic [CW-1:0]       csr_out;
  logic                csr_out_we;
  logic [RW-1:0]       data_reg_c;

  always #5 clk = ~clk;

  fpu_tile_arbiter #(
    .REG_WIDTH      (RW),
    .CSR_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op_a    (req_op_a),
    .req_op_b    (req_op_b),
    .req_sub     (req_sub),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_status  (rsp_status),
    .rsp_timeout (rsp_timeout),
    .data_reg_a  (data_reg_a),
    .data_reg_b  (data_reg_b),
    .csr_in      (csr_in),
    .csr_in_re   (csr_in_re),
    .csr_out     (csr_out),
    .csr_out_we  (csr_out_we),
    .data_reg_c  (data_reg_c)
  );

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic [15:0] status;
    logic        timeout;
  } rsp_t;

  typedef struct {
    logic [15:0] csr;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] ret;
    logic [15:0] exp_csr;
    logic [31:0] exp_res;
  } vec_t;

  rsp_t sb[$];
  iss_t iq[$];
  int   grant_log[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int re_cnt = 0;
  int rsp_cnt = 0;
  int hs_cyc = 0;
  int re_cyc = 0;
  int rsp_cyc = 0;
  int last_gap = 0;
  logic [31:0] last_result = '0;
  logic        last_timeout = 1'b0;
  logic        last_id = 1'b0;
  logic [15:0] last_csr = '0;

  // tile model controls, written only by the main sequence
  int          tile_delay = 1;
  bit          tile_silent = 1'b0;
  bit          tile_ovr = 1'b0;
  logic [31:0] tile_ret = '0;
  int          stray_req = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b, input logic s);
    return tile_ovr ? tile_ret : (a ^ b ^ {31'b0, s});
  endfunction

  // Tile model: answers tile_delay cycles after the issue strobe.
  initial begin
    int          pend;
    int          stray_done;
    logic [31:0] pc;
    logic [15:0] ps;
    pend = 0;
    stray_done = 0;
    pc = '0;
    ps = '0;
    csr_out_we = 1'b0;
    csr_out = '0;
    data_reg_c = '0;
    forever begin
      @(posedge clk);
      #2;
      csr_out_we = 1'b0;
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        csr_out_we = 1'b1;
        data_reg_c = 32'hDEADBEEF;
        csr_out = 16'hFFFF;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          csr_out_we = 1'b1;
          data_reg_c = pc;
          csr_out = ps;
        end
      end
      if (csr_in_re && !tile_silent) begin
        pend = tile_delay;
        pc = tile_ovr ? tile_ret : (data_reg_a ^ data_reg_b ^ {31'b0, csr_in[4]});
        ps = 16'h00A0 | {15'b0, csr_in[4]};
      end
    end
  end

  // Monitor / scoreboard, sampling 7 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #7;
      cyc++;
      if (!arst_n) continue;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          rsp_t e;
          iss_t s;
          e.id      = (i == 1);
          e.result  = tile_silent ? 32'h0 : exp_res(req_op_a[i], req_op_b[i], req_sub[i]);
          e.status  = tile_silent ? 16'h0 : (16'h00A0 | {15'b0, req_sub[i]});
          e.timeout = tile_silent;
          sb.push_back(e);
          s.csr = req_sub[i] ? 16'h8010 : 16'h8000;
          s.a   = req_op_a[i];
          s.b   = req_op_b[i];
          iq.push_back(s);
          grant_log.push_back(i);
          hs_cnt++;
          last_gap = cyc - rsp_cyc;
          hs_cyc = cyc;
        end
      end
      if (csr_in_re) begin
        re_cnt++;
        re_cyc = cyc;
        last_csr = csr_in;
        if (iq.size() == 0) begin
          chk("spurious_issue", 64'(csr_in_re), 64'd0);
        end else begin
          iss_t s;
          s = iq.pop_front();
          chk("issue_csr_in", 64'(csr_in), 64'(s.csr));
          chk("issue_data_a", 64'(data_reg_a), 64'(s.a));
          chk("issue_data_b", 64'(data_reg_b), 64'(s.b));
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        last_result = rsp_result;
        last_timeout = rsp_timeout;
        last_id = rsp_id;
        if (sb.size() == 0) begin
          chk("spurious_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_result", 64'(rsp_result), 64'(e.result));
          chk("rsp_status", 64'(rsp_status), 64'(e.status));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(rsp_cnt >= target), 64'd1);
  endtask

  task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    int base;
    base = hs_cnt;
    req_op_a[id] = a;
    req_op_b[id] = b;
    req_sub[id] = s;
    req_valid[id] = 1'b1;
    n = 0;
    while (hs_cnt == base && n < 50) begin
      tick();
      n++;
    end
    req_valid[id] = 1'b0;
    if (hs_cnt == base) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    int   base_r;
    int   base_re;
    int   base_h;

    vt[0] = '{0, 32'h41200000, 32'h40A00000, 1'b0, 32'h41700000, 16'h8000, 32'h41700000};
    vt[1] = '{1, 32'h41600000, 32'h40A00000, 1'b1, 32'h41100000, 16'h8010, 32'h41100000};
    vt[2] = '{0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 16'h8010, 32'h00000000};
    vt[3] = '{1, 32'h40000000, 32'h40400000, 1'b0, 32'h40A00000, 16'h8000, 32'h40A00000};

    arst_n = 1'b0;
    req_valid = 2'b11;
    req_op_a = '0;
    req_op_b = '0;
    req_sub = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    // reset values
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_status", 64'(rsp_status), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("rst_csr_in", 64'(csr_in), 64'd0);
    chk("rst_csr_in_re", 64'(csr_in_re), 64'd0);
    chk("rst_data_a", 64'(data_reg_a), 64'd0);
    chk("rst_data_b", 64'(data_reg_b), 64'd0);
    arst_n = 1'b1;
    #1;
    chk("release_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("first_tie_grant", 64'(req_ready), 64'd1);
    req_valid = 2'b00;
    tick();

    // table vectors, minimum-latency tile
    tile_ovr = 1'b1;
    tile_delay = 1;
    for (int i = 0; i < 4; i++) begin
      base_r = rsp_cnt;
      tile_ret = vt[i].ret;
      issue_one(vt[i].id, vt[i].a, vt[i].b, vt[i].sub);
      wait_rsp(base_r + 1, 40, "vec_rsp_arrived");
      chk("vec_csr_in", 64'(last_csr), 64'(vt[i].exp_csr));
      chk("vec_result", 64'(last_result), 64'(vt[i].exp_res));
      chk("vec_id", 64'(last_id), 64'(vt[i].id));
      chk("vec_latency", 64'(rsp_cyc - hs_cyc), 64'd3);
      tick();
    end
    tile_ovr = 1'b0;

    // round robin with both requesters held valid
    base_r = rsp_cnt;
    base_re = re_cnt;
    base_h = hs_cnt;
    grant_log.delete();
    req_op_a[0] = 32'h11110000; req_op_b[0] = 32'h00002222; req_sub[0] = 1'b0;
    req_op_a[1] = 32'h33330000; req_op_b[1] = 32'h00004444; req_sub[1] = 1'b1;
    req_valid = 2'b11;
    for (int n = 0; n < 200 && hs_cnt < base_h + 4; n++) tick();
    req_valid = 2'b00;
    wait_rsp(base_r + 4, 100, "rr_rsp_arrived");
    chk("rr_grant_count", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (grant_log.size() > k) chk("rr_grant_order", 64'(grant_log[k]), 64'(k % 2));
    end
    chk("rr_issue_per_rsp", 64'(re_cnt - base_re), 64'(rsp_cnt - base_r));
    chk("rr_back_to_back_gap", 64'(last_gap), 64'd1);
    tick();

    // response backpressure
    rsp_ready = 1'b0;
    base_r = rsp_cnt;
    issue_one(0, 32'h12345678, 32'h0F0F0F0F, 1'b0);
    for (int n = 0; n < 20 && !rsp_valid; n++) tick();
    req_op_a[1] = 32'h00FF00FF; req_op_b[1] = 32'h0000FFFF; req_sub[1] = 1'b0;
    req_valid[1] = 1'b1;
    base_re = re_cnt;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_result", 64'(rsp_result), 64'(32'h12345678 ^ 32'h0F0F0F0F));
      chk("bp_rsp_status", 64'(rsp_status), 64'h00A0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    chk("bp_no_issue", 64'(re_cnt - base_re), 64'd0);
    rsp_ready = 1'b1;
    base_h = hs_cnt;
    for (int n = 0; n < 20 && hs_cnt == base_h; n++) tick();
    req_valid[1] = 1'b0;
    wait_rsp(base_r + 2, 40, "bp_rsp_arrived");
    tick();

    // silent tile -> timeout
    tile_silent = 1'b1;
    base_r = rsp_cnt;
    issue_one(1, 32'hCAFE0000, 32'h00000001, 1'b0);
    wait_rsp(base_r + 1, 40, "to_rsp_arrived");
    tile_silent = 1'b0;
    chk("to_flag", 64'(last_timeout), 64'd1);
    chk("to_result", 64'(last_result), 64'd0);
    chk("to_latency", 64'(rsp_cyc - re_cyc), 64'd8);
    tick();

    // tile result lands exactly in the timeout cycle
    tile_delay = 7;
    base_r = rsp_cnt;
    issue_one(0, 32'hA5A50000, 32'h00005A5A, 1'b1);
    wait_rsp(base_r + 1, 40, "edge_rsp_arrived");
    chk("edge_timeout_flag", 64'(last_timeout), 64'd0);
    chk("edge_result", 64'(last_result), 64'(32'hA5A55A5B));
    chk("edge_latency", 64'(rsp_cyc - re_cyc), 64'd8);
    tick();

    // stray result strobe while idle
    stray_req++;
    tick();
    tick();
    chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);

    // reset during WAIT, tile answers after release
    tile_delay = 5;
    base_re = re_cnt;
    issue_one(1, 32'h55550000, 32'h0000AAAA, 1'b1);
    tick();
    tick();
    arst_n = 1'b0;
    #1;
    chk("mid_rst_csr_in", 64'(csr_in), 64'd0);
    chk("mid_rst_data_a", 64'(data_reg_a), 64'd0);
    sb.delete();
    iq.delete();
    tick();
    arst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    chk("post_rst_result", 64'(rsp_result), 64'd0);
    chk("post_rst_status", 64'(rsp_status), 64'd0);
    chk("post_rst_data_b", 64'(data_reg_b), 64'd0);
    chk("post_rst_issues", 64'(re_cnt - base_re), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
